// File: rtl/unified_mem_arbiter_if.sv
// Bundle of request ports, response ports and memory handshake signals
// shared between the fetch/memory pipeline stages, the arbiter and memory.
interface unified_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Instruction port
    logic                  i_req_i;
    logic [DATA_WIDTH-1:0] i_addr_i;
    logic [DATA_WIDTH-1:0] i_rdata_o;
    logic                  i_rvalid_o;
    logic                  i_err_o;

    // Data port
    logic                  d_req_i;
    logic                  d_we_i;
    logic [BE_WIDTH-1:0]   d_be_i;
    logic [DATA_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_rvalid_o;
    logic                  d_err_o;

    // Memory handshake
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Arbiter side: consumes requests and memory responses
    modport slave (
        input  i_req_i, i_addr_i,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output i_rdata_o, i_rvalid_o, i_err_o,
        output d_rdata_o, d_rvalid_o, d_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    // Environment side: pipeline requesters plus the memory itself
    modport master (
        output i_req_i, i_addr_i,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  i_rdata_o, i_rvalid_o, i_err_o,
        input  d_rdata_o, d_rvalid_o, d_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between the instruction fetch port and
// the data port. The winning request is registered, presented to memory
// with a req/ack handshake and answered with a one-cycle rvalid strobe.
// A watchdog turns a never-acknowledged request into an error response.
module unified_mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus
);
    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int CNT_WIDTH    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_LAST);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam bit   WATCHDOG_EN  = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_RESP
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e                state_q,      state_d;
    port_e                 owner_q,      owner_d;
    port_e                 last_grant_q, last_grant_d;
    logic                  we_q,         we_d;
    logic [BE_WIDTH-1:0]   be_q,         be_d;
    logic [DATA_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;
    logic                  err_q,        err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q,    d_rdata_d;

    port_e                 grant_port;
    logic                  timeout_hit;
    logic                  resp_i;
    logic                  resp_d;

    // Round-robin tie break: on a tie the port that did not win last time goes
    assign grant_port = (bus.d_req_i && (!bus.i_req_i || (last_grant_q == PORT_I)))
                        ? PORT_D : PORT_I;

    // Last watchdog cycle; a zero timeout disables the abort path entirely
    assign timeout_hit = WATCHDOG_EN && (cnt_q == CNT_LAST);

    // Next-state and datapath update for the IDLE -> SERVE -> RESP cycle
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_i || bus.d_req_i) begin
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    cnt_d        = '0;
                    state_d      = ST_SERVE;
                    if (grant_port == PORT_D) begin
                        we_d    = bus.d_we_i;
                        be_d    = bus.d_be_i;
                        addr_d  = bus.d_addr_i;
                        wdata_d = bus.d_wdata_i;
                    end else begin
                        we_d    = 1'b0;
                        be_d    = '1;
                        addr_d  = bus.i_addr_i;
                        wdata_d = '0;
                    end
                end
            end

            ST_SERVE: begin
                if (bus.mem_ack_i) begin
                    if (!we_q) begin
                        if (owner_q == PORT_D) begin
                            d_rdata_d = bus.mem_rdata_i;
                        end else begin
                            i_rdata_d = bus.mem_rdata_i;
                        end
                    end
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    if (!we_q) begin
                        if (owner_q == PORT_D) begin
                            d_rdata_d = '0;
                        end else begin
                            i_rdata_d = '0;
                        end
                    end
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign resp_i = (state_q == ST_RESP) && (owner_q == PORT_I);
    assign resp_d = (state_q == ST_RESP) && (owner_q == PORT_D);

    assign bus.mem_req_o   = (state_q == ST_SERVE);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_be_o    = be_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    assign bus.i_rvalid_o  = resp_i;
    assign bus.i_err_o     = resp_i && err_q;
    assign bus.i_rdata_o   = i_rdata_q;

    assign bus.d_rvalid_o  = resp_d;
    assign bus.d_err_o     = resp_d && err_q;
    assign bus.d_rdata_o   = d_rdata_q;
endmodule
